// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch / decode / execute sequencer that feeds the ALU
// datapath from a synchronous instruction memory. It stops on a HALT opcode,
// reports errors with a sticky cause, guards EXECUTE with a watchdog,
// supports single-stepping and abort, and counts retired instructions.
module instr_sequencer #(
  parameter  int DATA_W    = 8,
  parameter  int OPC_W     = 4,
  parameter  int ADDR      = 5,
  parameter  int NUM_OPS   = 4,
  parameter  int TIMEOUT   = 64,
  localparam int INSTR_LEN = OPC_W + 2*DATA_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 step_mode,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 done,
  output logic                 imem_rd_en,
  output logic [ADDR-1:0]      pc,
  output logic                 enable,
  output logic [OPC_W-1:0]     opcode,
  output logic [DATA_W-1:0]    a,
  output logic [DATA_W-1:0]    b,
  output logic                 busy,
  output logic                 halted,
  output logic                 paused,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [ADDR:0]        instr_count
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [OPC_W-1:0] HALT_OPC = '1;
  localparam logic [OPC_W:0]  NUM_OPS_V = (OPC_W+1)'(NUM_OPS);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PC_OVF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_PAUSE,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            r_state;
  logic [ADDR-1:0]   r_pc;
  logic [ADDR:0]     r_count;
  logic [1:0]        r_err;
  logic [OPC_W-1:0]  r_opc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [WD_W-1:0]   r_wd;
  logic              r_enable;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_halted;
  logic              r_paused;
  logic              r_error;

  state_t            w_state_nxt;
  logic [ADDR-1:0]   w_pc_nxt;
  logic [ADDR:0]     w_count_nxt;
  logic [1:0]        w_err_nxt;
  logic [OPC_W-1:0]  w_opc_nxt;
  logic [DATA_W-1:0] w_a_nxt;
  logic [DATA_W-1:0] w_b_nxt;
  logic [WD_W-1:0]   w_wd_nxt;

  logic [OPC_W-1:0]  w_instr_opc;
  logic [DATA_W-1:0] w_instr_a;
  logic [DATA_W-1:0] w_instr_b;

  assign w_instr_opc = instruction[INSTR_LEN-1 -: OPC_W];
  assign w_instr_a   = instruction[2*DATA_W-1 -: DATA_W];
  assign w_instr_b   = instruction[DATA_W-1:0];

  assign imem_rd_en  = r_rd_en;
  assign pc          = r_pc;
  assign enable      = r_enable;
  assign opcode      = r_opc;
  assign a           = r_a;
  assign b           = r_b;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign paused      = r_paused;
  assign error       = r_error;
  assign err_code    = r_err;
  assign instr_count = r_count;

  // Next-state and next-register logic; abort freezes pc/count/err for inspection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_opc_nxt   = r_opc;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_wd_nxt    = r_wd;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (go) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = '0;
            w_count_nxt = '0;
            w_err_nxt   = ERR_NONE;
          end
        end
        S_FETCH: begin
          w_state_nxt = S_DECODE;
        end
        S_DECODE: begin
          w_opc_nxt = w_instr_opc;
          w_a_nxt   = w_instr_a;
          w_b_nxt   = w_instr_b;
          w_wd_nxt  = '0;
          if (w_instr_opc == HALT_OPC) begin
            w_state_nxt = S_HALTED;
          end else if ({1'b0, w_instr_opc} >= NUM_OPS_V) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = ERR_OPCODE;
          end else begin
            w_state_nxt = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (done) begin
            w_count_nxt = r_count + 1'b1;
            if (&r_pc) begin
              w_state_nxt = S_ERROR;
              w_err_nxt   = ERR_PC_OVF;
            end else begin
              w_pc_nxt    = r_pc + 1'b1;
              w_state_nxt = step_mode ? S_PAUSE : S_FETCH;
            end
          end else if (r_wd == WD_LAST) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = ERR_TIMEOUT;
          end else begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end
        S_PAUSE: begin
          if (go) begin
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; status flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_count  <= '0;
      r_err    <= ERR_NONE;
      r_opc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wd     <= '0;
      r_enable <= 1'b0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_paused <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_count  <= w_count_nxt;
      r_err    <= w_err_nxt;
      r_opc    <= w_opc_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_wd     <= w_wd_nxt;
      r_enable <= (w_state_nxt == S_EXECUTE);
      r_rd_en  <= (w_state_nxt == S_FETCH);
      r_busy   <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                  (w_state_nxt == S_EXECUTE);
      r_halted <= (w_state_nxt == S_HALTED);
      r_paused <= (w_state_nxt == S_PAUSE);
      r_error  <= (w_state_nxt == S_ERROR);
    end
  end

endmodule
